dma_scheduler: RTL and testbench
================================

// Module: dma_scheduler
// PURPOSE
//  Shares the single DMA engine between NREQ hardware requesters (SPDIF Rx/Tx, loader, CPU proxy).
//  Round-robin arbitrates pending transfer descriptors and programs the DMA register window over Wishbone:
//  RD word, WR word, then CTL word with start.
//  Waits for the DMA done interrupt, then returns a done pulse to the winning requester.
// PARAMETERS
//  NREQ        4     number of requesters (2..8)
//  DMA_AWIDTH  12    DMA address width; count field is DMA_AWIDTH+1 bits
//  TIMEOUT_CYC 65535 watchdog limit in WAIT state (used only with DMA_SCHED_TIMEOUT_EN)
// PORTS
//  clk_i          in   1                   system clock
//  rst_i          in   1                   synchronous reset, active high
//  req_i          in   NREQ                per-requester transfer request, level, held until done_o
//  rd_dev_i       in   2*NREQ              source device per requester (slice k = [2k+1:2k])
//  rd_adr_i       in   NREQ*DMA_AWIDTH     source start address per requester
//  wr_dev_i       in   2*NREQ              destination device per requester
//  wr_adr_i       in   NREQ*DMA_AWIDTH     destination start address per requester
//  count_i        in   NREQ*(DMA_AWIDTH+1) transfer count per requester, passed verbatim
//  grant_o        out  NREQ                one-hot, high from ARB until done_o
//  done_o         out  NREQ                one-cycle pulse on completion (or timeout)
//  busy_o         out  1                   state != IDLE
//  err_o          out  1                   one-cycle pulse on watchdog abort (0 if macro off)
//  wbm_cyc_o      out  1                   Wishbone master cycle
//  wbm_stb_o      out  1                   Wishbone master strobe
//  wbm_we_o       out  1                   always 1 when stb high
//  wbm_sel_o      out  4                   always 4'hF
//  wbm_adr_o      out  16                  register offset 16'h0/16'h4/16'h8
//  wbm_dat_o      out  32                  register word
//  wbm_ack_i      in   1                   slave acknowledge
//  dma_irq_i      in   1                   DMA done pulse
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; RR pointer = 0. Reset mid-transfer aborts with no done_o pulse.
//  FSM:
//   IDLE -> ARB  when |req_i.
//   ARB:
//    - winner = first set req at or after ptr, wrapping;
//    - latch idx and that requester's descriptor;
//    - grant_o[idx] <= 1; ptr <= idx+1 mod NREQ; -> W_RD.
//    - If req_i dropped to 0 meanwhile -> IDLE, no grant.
//   W_RD: cyc/stb=1, adr=0x0, dat={rd_dev,zeros,rd_adr}. Advance on wbm_ack_i -> W_WR.
//   W_WR: adr=0x4, dat={wr_dev,zeros,wr_adr}. On ack -> W_GO.
//   W_GO: adr=0x8, dat={1'b1,zeros,count}. On ack -> WAIT; cyc/stb drop.
//   WAIT: on dma_irq_i -> DONE.
//   DONE: done_o[idx]=1 one cycle; grant_o cleared; -> IDLE.
//  Wishbone:
//   - cyc/stb held continuously through W_RD..W_GO; dat/adr change only on the cycle after ack.
//   - With a zero-wait slave (ack=stb), each write takes one cycle.
//  Latency, req at cycle 0, zero-wait slave:
//   - grant_o at cycle 2;
//   - writes in cycles 2,3,4;
//   - done_o one cycle after dma_irq_i sample.
//  Boundaries:
//   - Requests arriving during a transfer wait; descriptor inputs are ignored after ARB.
//   - dma_irq_i outside WAIT is ignored.
//   - Requester idx remaining high after done is eligible again, but only after all others (ptr moved).
//   - count_i=0 is forwarded unchanged.
//   - Zero-padding widths are 30-DMA_AWIDTH (RD/WR) and 30-DMA_AWIDTH (CTL).
// CONFIGURATION
//  DMA_SCHED_TIMEOUT_EN defined:
//   - 17-bit watchdog cleared on WAIT entry, increments in WAIT;
//   - at TIMEOUT_CYC: err_o and done_o[idx] pulse together, -> IDLE.
//  DMA_SCHED_TIMEOUT_EN undefined:
//   - no counter; WAIT exits only on dma_irq_i; err_o tied 0.
// STRUCTURE
//  Package dma_sched_pkg:
//   - state enum (IDLE, ARB, W_RD, W_WR, W_GO, WAIT, DONE);
//   - REG_RD=16'h0, REG_WR=16'h4, REG_CTL=16'h8;
//   - START_BIT=31; DEV_MSB=31, DEV_LSB=30.
//  Sub-module dma_rr_arbiter (NREQ): req, ptr -> one-hot winner + index, purely combinational.
// TESTING
//  1. Single req_i=4'b0001, rd 0/0x010, wr 3/0x200, count 0x00F:
//     -> writes 0x0=0x00000010, 0x4=0xC0000200, 0x8=0x8000000F; done_o=0001 one cycle after irq.
//  2. req_i=4'b1111 held, irq 5 cycles after each W_GO
//     -> grant order 0,1,2,3,0; no requester granted twice in a row.
//  3. Slave with 2-cycle ack delay
//     -> each word held stable until ack; exactly 3 acked writes per transfer.
//  4. rst_i pulsed in WAIT, then irq
//     -> all outputs 0, no done_o; next req re-arbitrates from ptr=0.
//  5. Spurious dma_irq_i in IDLE and W_WR
//     -> ignored; FSM waits for irq in WAIT.
//  6. DMA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=100, no irq
//     -> err_o and done_o pulse exactly 100 cycles after WAIT entry; busy_o=0 next cycle.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// Shared state encoding and DMA register map for the DMA request scheduler.
package dma_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        W_RD = 3'd2,
        W_WR = 3'd3,
        W_GO = 3'd4,
        WAIT = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [15:0] REG_RD  = 16'h0;
    localparam logic [15:0] REG_WR  = 16'h4;
    localparam logic [15:0] REG_CTL = 16'h8;

    localparam int START_BIT = 31;
    localparam int DEV_MSB   = 31;
    localparam int DEV_LSB   = 30;
    localparam int WD_W      = 17;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr_i, wrapping; combinational.
// No state and no backpressure; vld_o low when nothing is requesting.
module dma_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            vld_o
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_i) + i) % NREQ);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_scheduler.sv
// Arbitrates requesters onto one DMA engine: grant 2 cycles after req, three Wishbone writes held until ack,
// done pulse the cycle after dma_irq_i. Optional WAIT watchdog under DMA_SCHED_TIMEOUT_EN.
module dma_scheduler #(
    parameter int NREQ        = 4,
    parameter int DMA_AWIDTH  = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NREQ-1:0]                req_i,
    input  logic [2*NREQ-1:0]              rd_dev_i,
    input  logic [NREQ*DMA_AWIDTH-1:0]     rd_adr_i,
    input  logic [2*NREQ-1:0]              wr_dev_i,
    input  logic [NREQ*DMA_AWIDTH-1:0]     wr_adr_i,
    input  logic [NREQ*(DMA_AWIDTH+1)-1:0] count_i,
    output logic [NREQ-1:0]                grant_o,
    output logic [NREQ-1:0]                done_o,
    output logic                           busy_o,
    output logic                           err_o,
    output logic                           wbm_cyc_o,
    output logic                           wbm_stb_o,
    output logic                           wbm_we_o,
    output logic [3:0]                     wbm_sel_o,
    output logic [15:0]                    wbm_adr_o,
    output logic [31:0]                    wbm_dat_o,
    input  logic                           wbm_ack_i,
    input  logic                           dma_irq_i
);
    import dma_sched_pkg::*;

    localparam int IW = idx_width(NREQ);

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, idx_q, idx_d;
    logic [NREQ-1:0]         grant_q, grant_d;
    logic [1:0]              rd_dev_q, rd_dev_d, wr_dev_q, wr_dev_d;
    logic [DMA_AWIDTH-1:0]   rd_adr_q, rd_adr_d, wr_adr_q, wr_adr_d;
    logic [DMA_AWIDTH:0]     count_q, count_d;
    logic [NREQ-1:0]         arb_gnt;
    logic [IW-1:0]           arb_idx;
    logic                    arb_vld;
`ifdef DMA_SCHED_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    err_q, err_d;
`endif

    dma_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|req_i) state_d = ARB;
            ARB:  state_d = arb_vld ? W_RD : IDLE;
            W_RD: if (wbm_ack_i) state_d = W_WR;
            W_WR: if (wbm_ack_i) state_d = W_GO;
            W_GO: if (wbm_ack_i) state_d = WAIT;
            WAIT: begin
                if (dma_irq_i) state_d = DONE;
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (wd_q == WD_LAST) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_sel_o = 4'h0;
        wbm_adr_o = 16'h0;
        wbm_dat_o = 32'h0;
        done_o    = '0;
        busy_o    = (state_q != IDLE);
        grant_o   = grant_q;
`ifdef DMA_SCHED_TIMEOUT_EN
        err_o     = err_q;
`else
        err_o     = 1'b0;
`endif
        if (state_q == W_RD || state_q == W_WR || state_q == W_GO) begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_sel_o = 4'hF;
        end
        case (state_q)
            W_RD: begin
                wbm_adr_o                    = REG_RD;
                wbm_dat_o[DEV_MSB:DEV_LSB]   = rd_dev_q;
                wbm_dat_o[DMA_AWIDTH-1:0]    = rd_adr_q;
            end
            W_WR: begin
                wbm_adr_o                    = REG_WR;
                wbm_dat_o[DEV_MSB:DEV_LSB]   = wr_dev_q;
                wbm_dat_o[DMA_AWIDTH-1:0]    = wr_adr_q;
            end
            W_GO: begin
                wbm_adr_o                    = REG_CTL;
                wbm_dat_o[START_BIT]         = 1'b1;
                wbm_dat_o[DMA_AWIDTH:0]      = count_q;
            end
            DONE:    done_o[idx_q] = 1'b1;
            default: ;
        endcase
    end

    // Descriptor is captured once in ARB; later changes on the inputs cannot disturb a transfer.
    always_comb begin
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        grant_d  = grant_q;
        rd_dev_d = rd_dev_q;
        rd_adr_d = rd_adr_q;
        wr_dev_d = wr_dev_q;
        wr_adr_d = wr_adr_q;
        count_d  = count_q;
        if (state_q == ARB && arb_vld) begin
            idx_d   = arb_idx;
            grant_d = arb_gnt;
            ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            for (int k = 0; k < NREQ; k++) begin
                if (arb_gnt[k]) begin
                    rd_dev_d = rd_dev_i[2*k +: 2];
                    wr_dev_d = wr_dev_i[2*k +: 2];
                    rd_adr_d = rd_adr_i[k*DMA_AWIDTH +: DMA_AWIDTH];
                    wr_adr_d = wr_adr_i[k*DMA_AWIDTH +: DMA_AWIDTH];
                    count_d  = count_i[k*(DMA_AWIDTH+1) +: DMA_AWIDTH+1];
                end
            end
        end
        if (state_q == DONE) grant_d = '0;
`ifdef DMA_SCHED_TIMEOUT_EN
        wd_d  = wd_q;
        err_d = 1'b0;
        if (state_q == W_GO && wbm_ack_i) wd_d = '0;
        else if (state_q == WAIT)         wd_d = wd_q + 1'b1;
        if (state_q == WAIT && !dma_irq_i && wd_q == WD_LAST) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            rd_dev_q <= '0;
            rd_adr_q <= '0;
            wr_dev_q <= '0;
            wr_adr_q <= '0;
            count_q  <= '0;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            rd_dev_q <= rd_dev_d;
            rd_adr_q <= rd_adr_d;
            wr_dev_q <= wr_dev_d;
            wr_adr_q <= wr_adr_d;
            count_q  <= count_d;
`ifdef DMA_SCHED_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_dma_scheduler.sv
// Directed bench for dma_scheduler with a transaction-level round-robin / register-word model.
module tb_dma_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 12;
    localparam int TO   = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      rd_dev, wr_dev;
    logic [NREQ*AW-1:0]     rd_adr, wr_adr;
    logic [NREQ*(AW+1)-1:0] cnt;
    logic [NREQ-1:0]        grant_o, done_o;
    logic                   busy_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, irq;
    logic [3:0]             wbm_sel_o;
    logic [15:0]            wbm_adr_o;
    logic [31:0]            wbm_dat_o;
    logic                   irq_man, irq_auto;

    assign irq = irq_man | irq_auto;

    dma_scheduler #(.NREQ(NREQ), .DMA_AWIDTH(AW), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .rd_dev_i(rd_dev), .rd_adr_i(rd_adr), .wr_dev_i(wr_dev), .wr_adr_i(wr_adr), .count_i(cnt),
        .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .dma_irq_i(irq)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wishbone slave: acks after ack_dly extra wait cycles.
    int         ack_dly = 0;
    logic [3:0] wcnt = 4'd0;
    always @(posedge clk) begin
        if (rst || !wbm_stb_o || wbm_ack_i) wcnt <= 4'd0;
        else                                wcnt <= wcnt + 4'd1;
    end
    assign wbm_ack_i = wbm_stb_o && (wcnt == 4'(ack_dly));

    // DMA engine stand-in: irq irq_gap cycles after the third acked write of a transfer.
    bit auto_irq = 1'b0;
    int irq_gap  = 5;
    int a_cnt    = 0;
    int a_cd     = 0;
    initial begin
        irq_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                a_cnt = 0; a_cd = 0; irq_auto = 1'b0;
            end else begin
                if (a_cd > 0) begin
                    a_cd--;
                    irq_auto = (a_cd == 0);
                end else irq_auto = 1'b0;
                if (wbm_stb_o && wbm_ack_i) begin
                    a_cnt++;
                    if (a_cnt == 3) begin
                        a_cnt = 0;
                        if (auto_irq) a_cd = irq_gap;
                    end
                end
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic [NREQ-1:0]        m_gnt, req_p;
    int                     m_ptr, wn, wcyc, w;
    bit                     waiting, pend, pend_err, was_pend;
    logic [15:0]            exp_adr[3];
    logic [31:0]            exp_dat[3];
    logic [2*NREQ-1:0]      rdd_p, wrd_p;
    logic [NREQ*AW-1:0]     rda_p, wra_p;
    logic [NREQ*(AW+1)-1:0] cnt_p;
    logic                   stb_p, ack_p;
    logic [15:0]            adr_p;
    logic [31:0]            dat_p;
    int                     gnt_log[$];
    logic [31:0]            wlog_dat[$];
    logic [15:0]            wlog_adr[$];
    int                     done_cnt = 0, done_cyc = 0, gnt_cyc = 0, err_cyc = -1;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_gnt = '0; m_ptr = 0; wn = 0; wcyc = 0;
            waiting = 0; pend = 0; pend_err = 0; stb_p = 0; ack_p = 0;
        end else begin
            chk("done_o", done_o, pend ? m_gnt : '0);
            chk("err_o", err_o, pend_err);
            if (done_o != 0) begin done_cnt++; done_cyc = cyc; end
            if (err_o) err_cyc = cyc;
            was_pend = pend; pend = 0; pend_err = 0;

            if (m_gnt == 0 && grant_o != 0) begin
                w = rr_pick(req_p, m_ptr);
                chk("grant_new", grant_o, (w < 0) ? 64'd0 : (64'd1 << w));
                if (w >= 0) begin
                    m_gnt = NREQ'(1 << w);
                    m_ptr = (w + 1) % NREQ;
                    exp_adr[0] = 16'h0; exp_adr[1] = 16'h4; exp_adr[2] = 16'h8;
                    exp_dat[0] = {rdd_p[2*w +: 2], 18'd0, rda_p[w*AW +: AW]};
                    exp_dat[1] = {wrd_p[2*w +: 2], 18'd0, wra_p[w*AW +: AW]};
                    exp_dat[2] = {1'b1, 18'd0, cnt_p[w*(AW+1) +: AW+1]};
                    wn = 0;
                    gnt_log.push_back(w);
                    gnt_cyc = cyc;
                end
            end else chk("grant_o", grant_o, m_gnt);
            if (m_gnt != 0) chk("busy_o", busy_o, 1);
            else            chk("stb_idle", wbm_stb_o, 0);
            if (was_pend) m_gnt = '0;

            chk("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
            chk("we_eq_stb", wbm_we_o, wbm_stb_o);
            if (wbm_stb_o) chk("sel", wbm_sel_o, 4'hF);
            if (stb_p && !ack_p) begin
                chk("hold_adr", wbm_adr_o, adr_p);
                chk("hold_dat", wbm_dat_o, dat_p);
            end

            if (waiting) begin
                wcyc++;
                if (irq) begin pend = 1; waiting = 0; end
`ifdef DMA_SCHED_TIMEOUT_EN
                else if (wcyc == TO) begin pend = 1; pend_err = 1; waiting = 0; end
`endif
            end
            if (wbm_stb_o && wbm_ack_i) begin
                if (wn < 3) begin
                    chk("wb_adr", wbm_adr_o, exp_adr[wn]);
                    chk("wb_dat", wbm_dat_o, exp_dat[wn]);
                end else chk("extra_write", wn, 2);
                wlog_adr.push_back(wbm_adr_o);
                wlog_dat.push_back(wbm_dat_o);
                wn++;
                if (wn == 3) begin waiting = 1; wcyc = 0; end
            end
        end
        req_p = req; rdd_p = rd_dev; wrd_p = wr_dev; rda_p = rd_adr; wra_p = wr_adr; cnt_p = cnt;
        stb_p = wbm_stb_o; ack_p = wbm_ack_i; adr_p = wbm_adr_o; dat_p = wbm_dat_o;
    end

    // ---------------- directed stimulus ----------------
    task automatic set_desc(input int k, input logic [1:0] rdd, input logic [11:0] rda,
                            input logic [1:0] wrd, input logic [11:0] wra, input logic [12:0] c);
        rd_dev[2*k +: 2]       = rdd;
        rd_adr[k*AW +: AW]     = rda;
        wr_dev[2*k +: 2]       = wrd;
        wr_adr[k*AW +: AW]     = wra;
        cnt[k*(AW+1) +: AW+1]  = c;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_done", (done_cnt >= target), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    int c0, bg, bw, bd;
    int ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; rd_dev = '0; wr_dev = '0; rd_adr = '0; wr_adr = '0; cnt = '0;
        irq_man = 1'b0;
        tick(3);
        chk("rst_grant", grant_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_dat", wbm_dat_o, 0);
        rst = 1'b0;
        tick(1);

        // 1: single requester, literal words and latency
        set_desc(0, 2'd0, 12'h010, 2'd3, 12'h200, 13'h00F);
        c0 = cyc; req = 4'b0001;
        tick(1);
        chk("t1_arb_busy", busy_o, 1);
        chk("t1_arb_grant", grant_o, 0);
        tick(1);
        chk("t1_grant_lat", grant_o, 4'b0001);
        chk("t1_rd_stb", wbm_stb_o, 1);
        chk("t1_rd_adr", wbm_adr_o, 16'h0);
        tick(3);
        chk("t1_wait_stb", wbm_stb_o, 0);
        chk("t1_wait_busy", busy_o, 1);
        tick(2);
        irq_man = 1'b1;
        tick(1);
        irq_man = 1'b0;
        chk("t1_done", done_o, 4'b0001);
        chk("t1_done_cyc", cyc - c0, 8);
        req = '0;
        tick(1);
        chk("t1_done_clr", done_o, 0);
        chk("t1_grant_clr", grant_o, 0);
        chk("t1_idle", busy_o, 0);
        chk("t1_nwrites", wlog_dat.size(), 3);
        if (wlog_dat.size() == 3) begin
            chk("t1_w0", {wlog_adr[0], wlog_dat[0]}, {16'h0, 32'h0000_0010});
            chk("t1_w1", {wlog_adr[1], wlog_dat[1]}, {16'h4, 32'hC000_0200});
            chk("t1_w2", {wlog_adr[2], wlog_dat[2]}, {16'h8, 32'h8000_000F});
        end

        // 2: all requesting, round-robin order from ptr 0; requester 3 has count 0
        do_reset();
        for (int k = 0; k < NREQ; k++)
            set_desc(k, 2'(k), 12'(12'h100 + k), 2'(3 - k), 12'(12'h300 + k), (k == 3) ? 13'h0 : 13'(13'h20 + k));
        bg = gnt_log.size(); bw = wlog_dat.size(); bd = done_cnt;
        auto_irq = 1'b1; irq_gap = 5;
        req = 4'b1111;
        wait_done(bd + 5, 300);
        req = '0;
        tick(3);
        chk("t2_ngrants", gnt_log.size() - bg, 5);
        if (gnt_log.size() >= bg + 5) begin
            for (int i = 0; i < 5; i++) chk("t2_order", gnt_log[bg + i], ord[i]);
            for (int i = 0; i < 4; i++) chk("t2_no_repeat", gnt_log[bg + i] != gnt_log[bg + i + 1], 1);
        end
        if (wlog_dat.size() >= bw + 12) chk("t2_count0", wlog_dat[bw + 11], 32'h8000_0000);

        // 3: slave with two wait cycles per word
        ack_dly = 2;
        bw = wlog_dat.size(); bd = done_cnt;
        req = 4'b0010;
        wait_done(bd + 1, 100);
        req = '0;
        ack_dly = 0;
        chk("t3_nwrites", wlog_dat.size() - bw, 3);
        chk("t3_duration", done_cyc - gnt_cyc, 14);
        chk("t3_idle", busy_o, 0);
        tick(2);

        // 5: spurious irq in IDLE and W_WR; descriptor changed after ARB
        auto_irq = 1'b0;
        set_desc(2, 2'd2, 12'hABC, 2'd1, 12'h123, 13'h1FFF);
        irq_man = 1'b1;
        tick(1);
        irq_man = 1'b0;
        tick(1);
        chk("t5_idle_irq_busy", busy_o, 0);
        bw = wlog_dat.size();
        c0 = cyc; req = 4'b0100;
        tick(2);
        set_desc(2, 2'd0, 12'hFFF, 2'd0, 12'hFFF, 13'h0);
        tick(1);
        chk("t5_in_wr", wbm_adr_o, 16'h4);
        irq_man = 1'b1;
        tick(1);
        irq_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t5_no_done", done_o, 0);
        end
        irq_man = 1'b1;
        tick(1);
        irq_man = 1'b0;
        chk("t5_done", done_o, 4'b0100);
        req = '0;
        tick(1);
        if (wlog_dat.size() == bw + 3) begin
            chk("t5_w0", wlog_dat[bw], 32'h8000_0ABC);
            chk("t5_w1", wlog_dat[bw + 1], 32'h4000_0123);
            chk("t5_w2", wlog_dat[bw + 2], 32'h8000_1FFF);
        end else chk("t5_nwrites", wlog_dat.size() - bw, 3);

        // 4: reset while in WAIT, late irq ignored, pointer restarts at 0
        c0 = cyc; req = 4'b0100;
        tick(6);
        chk("t4_in_wait", busy_o && !wbm_stb_o && grant_o == 4'b0100, 1);
        rst = 1'b1; req = '0;
        tick(1);
        rst = 1'b0;
        chk("t4_rst_grant", grant_o, 0);
        chk("t4_rst_busy", busy_o, 0);
        chk("t4_rst_cyc", wbm_cyc_o, 0);
        chk("t4_rst_adr", wbm_adr_o, 0);
        irq_man = 1'b1;
        tick(1);
        irq_man = 1'b0;
        tick(2);
        chk("t4_no_done", done_o, 0);
        chk("t4_still_idle", busy_o, 0);
        auto_irq = 1'b1;
        bd = done_cnt;
        req = 4'b1001;
        wait_done(bd + 1, 100);
        req = '0;
        if (gnt_log.size() > 0) chk("t4_ptr_restart", gnt_log[gnt_log.size() - 1], 0);
        tick(2);

`ifdef DMA_SCHED_TIMEOUT_EN
        // 6: watchdog abort with no irq
        auto_irq = 1'b0;
        bd = done_cnt;
        req = 4'b0001;
        wait_done(bd + 1, 300);
        req = '0;
        chk("t6_timeout_cyc", done_cyc - (gnt_cyc + 3), TO);
        chk("t6_err_with_done", err_cyc, done_cyc);
        chk("t6_idle_after", busy_o, 0);
        tick(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
